// File: rtl/comp_sched_pkg.sv
// Shared types and constants for the comparator gamma-cycle scheduler.
//   state_e      : scheduler FSM states
//   cfg_addr_e   : cfg_addr encoding of the u parameter registers
//   U_*_DEF      : reset values of the u parameters
package comp_sched_pkg;

  localparam int unsigned U_W   = 7;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WINDOW,
    ST_EVAL,
    ST_UPDATE,
    ST_FINISH
  } state_e;

  typedef enum logic [1:0] {
    CFG_CAPTURE = 2'd0,
    CFG_MINUS   = 2'd1,
    CFG_BACKOFF = 2'd2,
    CFG_SEARCH  = 2'd3
  } cfg_addr_e;

  localparam logic [U_W-1:0] U_CAPTURE_DEF = 7'd78;
  localparam logic [U_W-1:0] U_MINUS_DEF   = 7'd60;
  localparam logic [U_W-1:0] U_BACKOFF_DEF = 7'd101;
  localparam logic [U_W-1:0] U_SEARCH_DEF  = 7'd38;

endpackage

// File: rtl/lfsr7.sv
// Maximal-length 7-bit Fibonacci LFSR, polynomial x^7 + x^6 + 1.
//   clk, rst : clock, synchronous active-high reset (loads seed)
//   en       : advance one step
//   seed     : reset value, must be non-zero
//   value    : current register contents
module lfsr7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] seed,
  output logic [6:0] value
);

  logic [6:0] value_q;

  // Shift left, feedback is bit7 ^ bit6 of the polynomial (indices 6 and 5).
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= seed;
    end else if (en) begin
      value_q <= {value_q[5:0], value_q[6] ^ value_q[5]};
    end
  end

  assign value = value_q;

endmodule

// File: rtl/comp_sched.sv
// Gamma-cycle scheduler for a stochastic comparator: clears the comparator,
// opens a sampling window, evaluates its output against an LFSR draw and
// issues a valid/ready weight update when the draw is within the probability.
//   clk, rst                   : clock, synchronous active-high reset
//   start, stop, num_gamma     : run control (num_gamma 0 = continuous)
//   cfg_we/cfg_addr/cfg_data   : u parameter writes, accepted in IDLE only
//   u_capture..u_search        : registered comparator parameters
//   comp_rst_b, window         : comparator clear (active low), sample window
//   comp_prob, comp_inc        : comparator outputs
//   upd_valid/upd_inc/upd_ready: weight-update handshake
//   busy, done, gamma_cnt      : run status
module comp_sched
  import comp_sched_pkg::*;
#(
  parameter int unsigned GAMMA_LEN  = 16,
  parameter int unsigned CLR_CYCLES = 2,
  parameter logic [6:0]  LFSR_SEED  = 7'h5A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       num_gamma,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [U_W-1:0]   cfg_data,
  output logic [U_W-1:0]   u_capture,
  output logic [U_W-1:0]   u_minus,
  output logic [U_W-1:0]   u_backoff,
  output logic [U_W-1:0]   u_search,
  output logic             comp_rst_b,
  output logic             window,
  input  logic [U_W-1:0]   comp_prob,
  input  logic             comp_inc,
  output logic             upd_valid,
  output logic             upd_inc,
  input  logic             upd_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] gamma_cnt
);

  localparam int unsigned WIN_CYCLES = GAMMA_LEN - CLR_CYCLES - 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] gamma_q, gamma_d;
  logic             stop_q, stop_d;
  logic             upd_valid_q, upd_valid_d;
  logic             upd_inc_q, upd_inc_d;
  logic             comp_rst_b_q, window_q, busy_q, done_q;
  logic [U_W-1:0]   u_capture_q, u_minus_q, u_backoff_q, u_search_q;
  logic             lfsr_en;
  logic [6:0]       lfsr_val;
  logic             gamma_end;
  logic             last_gamma;
  logic             cfg_wr;

  lfsr7 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (lfsr_en),
    .seed  (LFSR_SEED),
    .value (lfsr_val)
  );

  assign last_gamma = (num_gamma != 8'd0) &&
                      (CNT_W'(gamma_q + CNT_W'(1)) == num_gamma);

  // Next-state logic. A gamma without an update request skips the UPDATE
  // cycle entirely, so a quiet gamma is exactly GAMMA_LEN cycles long.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gamma_d     = gamma_q;
    upd_valid_d = upd_valid_q;
    upd_inc_d   = upd_inc_q;
    lfsr_en     = 1'b0;
    gamma_end   = 1'b0;
    // stop alone in IDLE is ignored; together with start it is kept
    stop_d      = stop_q | (stop & ((state_q != ST_IDLE) | start));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          gamma_d = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
          state_d = ST_WINDOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WINDOW: begin
        if (cnt_q == CNT_W'(WIN_CYCLES - 1)) begin
          state_d = ST_EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        // Capture the comparator and compare against this gamma's draw
        lfsr_en   = 1'b1;
        upd_inc_d = comp_inc;
        if (lfsr_val <= comp_prob) begin
          state_d     = ST_UPDATE;
          upd_valid_d = 1'b1;
        end else begin
          gamma_end = 1'b1;
        end
      end
      ST_UPDATE: begin
        if (upd_ready) begin
          upd_valid_d = 1'b0;
          gamma_end   = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        stop_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Gamma boundary: count it and decide whether the run continues
    if (gamma_end) begin
      gamma_d = gamma_q + CNT_W'(1);
      cnt_d   = '0;
      state_d = (last_gamma || stop_q) ? ST_FINISH : ST_CLEAR;
    end
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      gamma_q      <= '0;
      stop_q       <= 1'b0;
      upd_valid_q  <= 1'b0;
      upd_inc_q    <= 1'b0;
      comp_rst_b_q <= 1'b0;
      window_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gamma_q      <= gamma_d;
      stop_q       <= stop_d;
      upd_valid_q  <= upd_valid_d;
      upd_inc_q    <= upd_inc_d;
      comp_rst_b_q <= (state_d != ST_CLEAR);
      window_q     <= (state_d == ST_WINDOW);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_FINISH);
    end
  end

  // Parameters only change while idle and not about to start
  assign cfg_wr = cfg_we && (state_q == ST_IDLE) && !start;

  always_ff @(posedge clk) begin
    if (rst) begin
      u_capture_q <= U_CAPTURE_DEF;
      u_minus_q   <= U_MINUS_DEF;
      u_backoff_q <= U_BACKOFF_DEF;
      u_search_q  <= U_SEARCH_DEF;
    end else if (cfg_wr) begin
      case (cfg_addr)
        CFG_CAPTURE: u_capture_q <= cfg_data;
        CFG_MINUS:   u_minus_q   <= cfg_data;
        CFG_BACKOFF: u_backoff_q <= cfg_data;
        default:     u_search_q  <= cfg_data;
      endcase
    end
  end

  assign u_capture  = u_capture_q;
  assign u_minus    = u_minus_q;
  assign u_backoff  = u_backoff_q;
  assign u_search   = u_search_q;
  assign comp_rst_b = comp_rst_b_q;
  assign window     = window_q;
  assign upd_valid  = upd_valid_q;
  assign upd_inc    = upd_inc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign gamma_cnt  = gamma_q;

endmodule

// File: tb/tb_comp_sched.sv
// Directed self-checking bench for comp_sched.
module tb_comp_sched;

  logic       clk = 1'b0;
  logic       rst, start, stop, cfg_we, comp_inc, upd_ready;
  logic [7:0] num_gamma;
  logic [1:0] cfg_addr;
  logic [6:0] cfg_data, comp_prob;
  logic [6:0] u_capture, u_minus, u_backoff, u_search;
  logic       comp_rst_b, window, upd_valid, upd_inc, busy, done;
  logic [7:0] gamma_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // run statistics gathered by watch_run
  int n_clr, first_clr, last_clr, n_win, n_valid, inc_bad, drop_bad;
  int n_done, done_at, hs_crb, timed_out;

  always #5 clk = ~clk;

  comp_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .num_gamma  (num_gamma),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .u_capture  (u_capture),
    .u_minus    (u_minus),
    .u_backoff  (u_backoff),
    .u_search   (u_search),
    .comp_rst_b (comp_rst_b),
    .window     (window),
    .comp_prob  (comp_prob),
    .comp_inc   (comp_inc),
    .upd_valid  (upd_valid),
    .upd_inc    (upd_inc),
    .upd_ready  (upd_ready),
    .busy       (busy),
    .done       (done),
    .gamma_cnt  (gamma_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ucap"}, 32'(u_capture), 32'd78);
    check_eq({tag, "_umin"}, 32'(u_minus), 32'd60);
    check_eq({tag, "_uback"}, 32'(u_backoff), 32'd101);
    check_eq({tag, "_usrch"}, 32'(u_search), 32'd38);
    check_eq({tag, "_crb"}, 32'(comp_rst_b), 32'd0);
    check_eq({tag, "_win"}, 32'(window), 32'd0);
    check_eq({tag, "_uv"}, 32'(upd_valid), 32'd0);
    check_eq({tag, "_ui"}, 32'(upd_inc), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_gcnt"}, 32'(gamma_cnt), 32'd0);
  endtask

  // Observe a run sample by sample (sample c = after the c-th edge counting
  // the start edge) until busy falls; optionally back-pressures the update
  // by `hold` cycles and pulses stop during sample `stop_at`.
  task automatic watch_run(input int max_cyc, input int hold, input int stop_at);
    int   vrun;
    logic pv, pr, vinc;
    n_clr = 0; first_clr = -1; last_clr = -1; n_win = 0; n_valid = 0;
    inc_bad = 0; drop_bad = 0; n_done = 0; done_at = -1; hs_crb = -1;
    timed_out = 1; vrun = 0; pv = 1'b0; pr = 1'b0; vinc = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (!comp_rst_b) begin
        n_clr++;
        if (first_clr < 0) begin
          first_clr = c;
          last_clr  = c;
        end else if (last_clr == c - 1) begin
          last_clr = c;
        end
      end
      if (window) n_win++;
      if (pv && pr && hs_crb < 0) hs_crb = int'(comp_rst_b);
      if (pv && !pr && (!upd_valid || upd_inc !== vinc)) drop_bad++;
      if (upd_valid) begin
        n_valid++;
        vrun++;
        if (vrun == 1) vinc = upd_inc;
        if (upd_inc !== comp_inc) inc_bad++;
      end else begin
        vrun = 0;
      end
      if (done) begin
        n_done++;
        done_at = c;
      end
      if (!busy) begin
        timed_out = 0;
        break;
      end
      upd_ready = upd_valid && (vrun > hold);
      stop      = (c == stop_at);
      pv = upd_valid;
      pr = upd_ready;
      tick();
    end
    stop      = 1'b0;
    upd_ready = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0;
    cfg_data = 7'd0; num_gamma = 8'd1; comp_prob = 7'd0; comp_inc = 1'b0;
    upd_ready = 1'b0;
    tick();
    do_reset();
    check_reset("rst");

    // config: write in IDLE, dropped write and ignored start while busy
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 7'd17;
    tick();
    cfg_we = 1'b0;
    check_eq("cfg_uback", 32'(u_backoff), 32'd17);
    check_eq("cfg_ucap", 32'(u_capture), 32'd78);
    num_gamma = 8'd1; comp_prob = 7'd0;
    start_run();
    cfg_we = 1'b1; cfg_data = 7'd5; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    check_eq("cfg_busy_uback", 32'(u_backoff), 32'd17);
    watch_run(60, 0, -1);
    check_eq("cfg_done_at", 32'(done_at), 32'd16);
    check_eq("cfg_gcnt", 32'(gamma_cnt), 32'd1);
    check_eq("cfg_ndone", 32'(n_done), 32'd1);

    // defaults run, always update
    num_gamma = 8'd1; comp_prob = 7'd127; comp_inc = 1'b1;
    start_run();
    watch_run(60, 0, -1);
    check_eq("def_timeout", 32'(timed_out), 32'd0);
    check_eq("def_first_clr", 32'(first_clr), 32'd1);
    check_eq("def_last_clr", 32'(last_clr), 32'd2);
    check_eq("def_nclr", 32'(n_clr), 32'd2);
    check_eq("def_nwin", 32'(n_win), 32'd13);
    check_eq("def_nvalid", 32'(n_valid), 32'd1);
    check_eq("def_incbad", 32'(inc_bad), 32'd0);
    check_eq("def_ndone", 32'(n_done), 32'd1);
    check_eq("def_done_at", 32'(done_at), 32'd18);
    check_eq("def_gcnt", 32'(gamma_cnt), 32'd1);
    check_eq("def_uback_held", 32'(u_backoff), 32'd17);

    // never update
    num_gamma = 8'd5; comp_prob = 7'd0;
    start_run();
    watch_run(200, 0, -1);
    check_eq("nev_nvalid", 32'(n_valid), 32'd0);
    check_eq("nev_done_at", 32'(done_at), 32'd81);
    check_eq("nev_nwin", 32'(n_win), 32'd65);
    check_eq("nev_gcnt", 32'(gamma_cnt), 32'd5);

    // backpressure: ready low for 7 valid cycles, two gammas
    num_gamma = 8'd2; comp_prob = 7'd127; comp_inc = 1'b0;
    start_run();
    watch_run(200, 7, -1);
    check_eq("bp_nvalid", 32'(n_valid), 32'd16);
    check_eq("bp_dropbad", 32'(drop_bad), 32'd0);
    check_eq("bp_incbad", 32'(inc_bad), 32'd0);
    check_eq("bp_clr_after_hs", 32'(hs_crb), 32'd0);
    check_eq("bp_done_at", 32'(done_at), 32'd49);
    check_eq("bp_gcnt", 32'(gamma_cnt), 32'd2);

    // stop pulsed in the window of gamma 3, continuous run
    num_gamma = 8'd0; comp_prob = 7'd127; comp_inc = 1'b1;
    start_run();
    watch_run(300, 0, 40);
    check_eq("stop_timeout", 32'(timed_out), 32'd0);
    check_eq("stop_done_at", 32'(done_at), 32'd52);
    check_eq("stop_ndone", 32'(n_done), 32'd1);
    check_eq("stop_gcnt", 32'(gamma_cnt), 32'd3);
    check_eq("stop_busy", 32'(busy), 32'd0);

    // start and stop together in IDLE: one gamma
    num_gamma = 8'd0; comp_prob = 7'd0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    watch_run(100, 0, -1);
    check_eq("ss_timeout", 32'(timed_out), 32'd0);
    check_eq("ss_done_at", 32'(done_at), 32'd17);
    check_eq("ss_gcnt", 32'(gamma_cnt), 32'd1);

    // LFSR boundaries: seed 0x5A = 90, next draw 0x35 = 53
    num_gamma = 8'd1; comp_prob = 7'd90;
    do_reset();
    start_run();
    watch_run(60, 0, -1);
    check_eq("lf_eq_nvalid", 32'(n_valid), 32'd1);
    comp_prob = 7'd89;
    do_reset();
    start_run();
    watch_run(60, 0, -1);
    check_eq("lf_below_nvalid", 32'(n_valid), 32'd0);
    check_eq("lf_below_done_at", 32'(done_at), 32'd17);
    num_gamma = 8'd2; comp_prob = 7'd53;
    do_reset();
    start_run();
    watch_run(100, 0, -1);
    check_eq("lf_step_nvalid", 32'(n_valid), 32'd1);
    check_eq("lf_step_done_at", 32'(done_at), 32'd34);

    // reset in the middle of an update handshake
    num_gamma = 8'd1; comp_prob = 7'd127; comp_inc = 1'b1; upd_ready = 1'b0;
    start_run();
    for (int i = 0; i < 40 && !upd_valid; i++) tick();
    check_eq("mr_valid_seen", 32'(upd_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("mr");
    begin
      int dn = 0;
      int bz = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (done) dn++;
        if (busy) bz++;
      end
      check_eq("mr_no_done", 32'(dn), 32'd0);
      check_eq("mr_idle", 32'(bz), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comp_sched.md
COMP_SCHED -- requirements
Module: comp_sched

Interface
REQ-001 SHALL have parameters: GAMMA_LEN = 16 (cycles per gamma cycle, at least CLR_CYCLES+2); CLR_CYCLES = 2 (cycles of comparator clear); LFSR_SEED = 7'h5A (non-zero).
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  request a halt at the next gamma boundary.
- num_gamma  in  8  gamma cycles per run; 0 = run continuously.
- cfg_we  in  1  write strobe for a u parameter.
- cfg_addr  in  2  parameter select: 0 capture, 1 minus, 2 backoff, 3 search.
- cfg_data  in  7  parameter value.
- u_capture, u_minus, u_backoff, u_search  out  7 each  registered parameters driven to the comparator.
- comp_rst_b  out  1  active-low clear to the comparator.
- window  out  1  pulse-sampling window is open.
- comp_prob  in  7  comparator probability output.
- comp_inc  in  1  comparator direction output.
- upd_valid  out  1  weight-update request.
- upd_inc  out  1  update direction (1 = increment).
- upd_ready  in  1  update accepted.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a run ends.
- gamma_cnt  out  8  completed gamma cycles in the current run.

Function
REQ-003 SHALL implement an FSM with states IDLE, CLEAR, WINDOW, EVAL, UPDATE and FINISH.
- IDLE to CLEAR: start=1.
- CLEAR lasts CLR_CYCLES cycles, then WINDOW.
- WINDOW lasts GAMMA_LEN-CLR_CYCLES-1 cycles, then EVAL.
- EVAL lasts 1 cycle, then UPDATE.
- UPDATE to CLEAR or FINISH: on handshake completion, or immediately if no request is made.
- FINISH lasts 1 cycle, then IDLE.
REQ-004 SHALL drive comp_rst_b=0 only in CLEAR and 1 in every other state.
REQ-005 SHALL drive window=1 only in WINDOW.
REQ-006 SHALL capture comp_prob and comp_inc into registers in the EVAL cycle.
REQ-007 SHALL advance the internal 7-bit LFSR exactly once per gamma, in EVAL.
REQ-008 SHALL issue an update in UPDATE when lfsr_value <= captured prob, with upd_valid=1 and upd_inc = captured inc.
REQ-009 SHALL follow valid/ready rules for the update: upd_valid and upd_inc stay stable until a cycle with upd_valid & upd_ready; upd_valid drops the cycle after that handshake.
REQ-010 SHALL leave UPDATE without asserting upd_valid when lfsr_value > prob.
- prob=0: never updates, because the LFSR is never 0.
- prob=127: always updates.
REQ-011 SHALL increment gamma_cnt, wrapping at 255, when leaving UPDATE, and clear it on start.
REQ-012 SHALL go from UPDATE to FINISH when num_gamma≠0 and gamma_cnt+1 == num_gamma, or when a stop is latched; otherwise to CLEAR.
REQ-013 SHALL latch stop in any non-IDLE state and honour it only at the UPDATE exit; the current gamma, including a pending handshake, always completes.
REQ-014 SHALL assert done for exactly the FINISH cycle and clear the stop latch there.
REQ-015 SHALL ignore start while busy=1; if start and stop arrive together in IDLE, start wins and stop is latched (run ends after one gamma).
REQ-016 SHALL accept cfg_we only in IDLE, writing cfg_data to the register selected by cfg_addr from the next cycle; writes while busy are dropped.
REQ-017 SHALL hold u parameters constant for the whole run.

Reset
REQ-018 SHALL, on rst=1 at a clock edge, enter IDLE and apply these values:
- u_capture=78, u_minus=60, u_backoff=101, u_search=38.
- LFSR = LFSR_SEED; gamma_cnt=0; stop latch cleared.
- comp_rst_b=0 (comparator held clear during reset); window=0, upd_valid=0, upd_inc=0, busy=0, done=0.
REQ-019 SHALL let rst mid-run abort immediately, dropping upd_valid without a handshake and emitting no done.

Structure
REQ-020 SHALL place the state enum, the cfg_addr encoding and the default u constants in package comp_sched_pkg.
REQ-021 SHALL instantiate sub-module lfsr7: a maximal-length 7-bit Fibonacci LFSR, taps x^7+x^6+1, with inputs en and seed.

Verification
REQ-022 SHALL pass a defaults run: reset, start, num_gamma=1, comp_prob=127, comp_inc=1, upd_ready=1 -> comp_rst_b low for cycles 1-2, window high for 13 cycles, one upd_valid with upd_inc=1, done 1 cycle, gamma_cnt=1.
REQ-023 SHALL pass a never-update run: comp_prob=0, num_gamma=5 -> upd_valid never asserted, done after 5×GAMMA_LEN+1 cycles from start, gamma_cnt=5.
REQ-024 SHALL pass a backpressure run: comp_prob=127, upd_ready held 0 for 7 cycles -> upd_valid and upd_inc stable throughout, next CLEAR starts the cycle after the handshake.
REQ-025 SHALL pass a stop run: num_gamma=0, stop pulsed in WINDOW of gamma 3 -> gamma 3 completes, done pulses, gamma_cnt=3, busy falls.
REQ-026 SHALL pass a config run: write cfg_addr=2, data 17 in IDLE -> u_backoff=17; write while busy -> u_backoff unchanged; start while busy -> ignored.
REQ-027 SHALL pass a mid-run reset: rst asserted during UPDATE with upd_valid=1 -> next cycle IDLE, upd_valid=0, all outputs at REQ-018 values.
